// File: rtl/adder64_carry_select.sv
// adder64_carry_select: ripple-carry and two-stage carry-select adders plus a
// behavioural golden sum, all registered together with per-path mismatch flags.
// SPLIT must satisfy 0 < SPLIT < WIDTH; the lower carry-select stage is [SPLIT-1:0].
module adder64_carry_select #(
  parameter int WIDTH = 64,
  parameter int SPLIT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s_ripple,
  output logic             cout_ripple,
  output logic [WIDTH-1:0] s_csel,
  output logic             cout_csel,
  output logic [WIDTH-1:0] s_ref,
  output logic             cout_ref,
  output logic             err_ripple,
  output logic             err_csel
);

  localparam int UW = WIDTH - SPLIT;

  // ripple-carry path
  logic [WIDTH:0]   w_rc;
  logic [WIDTH-1:0] w_rs;

  // carry-select path: lower stage plus two speculative upper stages
  logic [SPLIT:0]   w_lc;
  logic [SPLIT-1:0] w_ls;
  logic [UW:0]      w_u0c;
  logic [UW:0]      w_u1c;
  logic [UW-1:0]    w_u0s;
  logic [UW-1:0]    w_u1s;
  logic [UW-1:0]    w_us;
  logic             w_cl;
  logic             w_cs_cout;

  // golden model and comparison
  logic [WIDTH:0]   w_ref;
  logic             w_err_ripple;
  logic             w_err_csel;

  // output registers
  logic [WIDTH-1:0] r_s_ripple;
  logic             r_cout_ripple;
  logic [WIDTH-1:0] r_s_csel;
  logic             r_cout_csel;
  logic [WIDTH-1:0] r_s_ref;
  logic             r_cout_ref;
  logic             r_err_ripple;
  logic             r_err_csel;

  assign w_rc[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_rca
    assign w_rs[i]   = a[i] ^ b[i] ^ w_rc[i];
    assign w_rc[i+1] = (a[i] & b[i]) | (a[i] & w_rc[i]) | (b[i] & w_rc[i]);
  end

  assign w_lc[0] = cin;

  for (genvar i = 0; i < SPLIT; i++) begin : g_lo
    assign w_ls[i]   = a[i] ^ b[i] ^ w_lc[i];
    assign w_lc[i+1] = (a[i] & b[i]) | (a[i] & w_lc[i]) | (b[i] & w_lc[i]);
  end

  assign w_cl     = w_lc[SPLIT];
  assign w_u0c[0] = 1'b0;
  assign w_u1c[0] = 1'b1;

  for (genvar i = 0; i < UW; i++) begin : g_hi
    assign w_u0s[i]   = a[SPLIT+i] ^ b[SPLIT+i] ^ w_u0c[i];
    assign w_u0c[i+1] = (a[SPLIT+i] & b[SPLIT+i]) | (a[SPLIT+i] & w_u0c[i]) |
                        (b[SPLIT+i] & w_u0c[i]);
    assign w_u1s[i]   = a[SPLIT+i] ^ b[SPLIT+i] ^ w_u1c[i];
    assign w_u1c[i+1] = (a[SPLIT+i] & b[SPLIT+i]) | (a[SPLIT+i] & w_u1c[i]) |
                        (b[SPLIT+i] & w_u1c[i]);
    // lower-stage carry picks which speculative upper bit is real
    assign w_us[i]    = w_cl ? w_u1s[i] : w_u0s[i];
  end

  assign w_cs_cout = w_cl ? w_u1c[UW] : w_u0c[UW];

  assign w_ref = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

  // full WIDTH+1 bit compare so a wrong carry-out is caught as well as a wrong sum
  assign w_err_ripple = ({w_rc[WIDTH], w_rs} != w_ref);
  assign w_err_csel   = ({w_cs_cout, w_us, w_ls} != w_ref);

  // register all results and flags from the same cycle; reset clears everything
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_ripple    <= '0;
      r_cout_ripple <= 1'b0;
      r_s_csel      <= '0;
      r_cout_csel   <= 1'b0;
      r_s_ref       <= '0;
      r_cout_ref    <= 1'b0;
      r_err_ripple  <= 1'b0;
      r_err_csel    <= 1'b0;
    end else begin
      r_s_ripple    <= w_rs;
      r_cout_ripple <= w_rc[WIDTH];
      r_s_csel      <= {w_us, w_ls};
      r_cout_csel   <= w_cs_cout;
      r_s_ref       <= w_ref[WIDTH-1:0];
      r_cout_ref    <= w_ref[WIDTH];
      r_err_ripple  <= w_err_ripple;
      r_err_csel    <= w_err_csel;
    end
  end

  assign s_ripple    = r_s_ripple;
  assign cout_ripple = r_cout_ripple;
  assign s_csel      = r_s_csel;
  assign cout_csel   = r_cout_csel;
  assign s_ref       = r_s_ref;
  assign cout_ref    = r_cout_ref;
  assign err_ripple  = r_err_ripple;
  assign err_csel    = r_err_csel;

endmodule

// File: tb/tb_adder64_carry_select.sv
// Bench for adder64_carry_select: directed vectors with hand-computed sums,
// reset behaviour, then a random back-to-back stream with reset pulses.
module tb_adder64_carry_select;

  logic        clk;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic [63:0] s_ripple;
  logic        cout_ripple;
  logic [63:0] s_csel;
  logic        cout_csel;
  logic [63:0] s_ref;
  logic        cout_ref;
  logic        err_ripple;
  logic        err_csel;

  int n_total = 0;
  int n_bad   = 0;

  adder64_carry_select #(.WIDTH(64), .SPLIT(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .a           (a),
    .b           (b),
    .cin         (cin),
    .s_ripple    (s_ripple),
    .cout_ripple (cout_ripple),
    .s_csel      (s_csel),
    .cout_csel   (cout_csel),
    .s_ref       (s_ref),
    .cout_ref    (cout_ref),
    .err_ripple  (err_ripple),
    .err_csel    (err_csel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // check all three paths against one expected {cout,sum}, flags expected clear
  task automatic chk_all(input string tag, input logic [64:0] exp);
    chk({tag, " ripple"}, {cout_ripple, s_ripple}, exp);
    chk({tag, " csel"},   {cout_csel, s_csel},     exp);
    chk({tag, " ref"},    {cout_ref, s_ref},       exp);
    chk({tag, " errs"},   {63'd0, err_ripple, err_csel}, 65'd0);
  endtask

  task automatic apply(input logic [63:0] ta, input logic [63:0] tb_, input logic tc);
    a   = ta;
    b   = tb_;
    cin = tc;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       tag;
    logic [63:0] va;
    logic [63:0] vb;
    logic        vc;
    logic [64:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    rst = 1'b1;
    a   = 64'hDEAD_BEEF_0123_4567;
    b   = 64'hFFFF_0000_FFFF_0000;
    cin = 1'b1;

    // reset held for two edges with live operands: outputs must be zero
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      chk_all("reset", 65'd0);
    end

    rst = 1'b0;
    vecs.push_back('{"full_wrap",  64'hFFFF_FFFF_FFFF_FFFF, 64'h1,   1'b1, {1'b1, 64'h1}});
    vecs.push_back('{"lo_wrap",    64'hFFFF_FFFF_FFFF_FFAA, 64'h111, 1'b1, {1'b1, 64'hBC}});
    vecs.push_back('{"small_c0",   64'h1110111, 64'h111, 1'b0, {1'b0, 64'h1110222}});
    vecs.push_back('{"small_c1",   64'h1110111, 64'h111, 1'b1, {1'b0, 64'h1110223}});
    vecs.push_back('{"one_one",    64'h1, 64'h1, 1'b0, {1'b0, 64'h2}});
    vecs.push_back('{"split_carry",64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, {1'b0, 64'h0000_0001_0000_0000}});
    vecs.push_back('{"zero_cin",   64'h0, 64'h0, 1'b1, {1'b0, 64'h1}});
    vecs.push_back('{"split_cin",  64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, {1'b0, 64'h0000_0001_0000_0000}});
    vecs.push_back('{"top_carry",  64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, {1'b1, 64'h0}});
    vecs.push_back('{"hi_sel1",    64'hFFFF_FFFF_8000_0000, 64'h0000_0000_8000_0000, 1'b0, {1'b1, 64'h0}});

    foreach (vecs[i]) begin
      apply(vecs[i].va, vecs[i].vb, vecs[i].vc);
      chk_all(vecs[i].tag, vecs[i].exp);
    end

    // random stream, one operand set per cycle, occasional reset pulses
    for (int n = 0; n < 10000; n++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      logic        rc;
      logic [64:0] exp;
      int          mode;
      mode = int'($urandom_range(0, 3));
      ra   = {$urandom, $urandom};
      rb   = {$urandom, $urandom};
      rc   = 1'($urandom_range(0, 1));
      if (mode == 1) rb = ~ra;
      if (mode == 2) begin
        ra[31:0] = 32'hFFFF_FFFF;
        rb[31:0] = {31'd0, 1'b1};
      end
      rst = ($urandom_range(0, 199) == 0);
      exp = rst ? 65'd0 : ({1'b0, ra} + {1'b0, rb} + {64'd0, rc});
      apply(ra, rb, rc);
      chk_all(rst ? "rnd_rst" : "rnd", exp);
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
